// File: rtl/sta_skew_feeder.sv
// Edge feeder for the systolic tensor array: accepts one operand vector per
// handshake, emits it diagonally skewed (lane l lags lane 0 by l cycles),
// drains the skew pipeline after the last beat of a tile and reports the
// tile length with a one-cycle completion pulse.
module sta_skew_feeder #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BEATS = 255,
    // Derived beat-counter width; leave at its default.
    parameter int unsigned CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_last_i,
    input  logic [LANES*W-1:0]   in_data_i,
    output logic [LANES*W-1:0]   lane_data_o,
    output logic [LANES-1:0]     lane_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CW-1:0]        tile_beats_o
);

    // Drain counter must hold LANES-1; keep at least one bit for LANES=1.
    localparam int unsigned DCW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   tile_beats_q, tile_beats_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            accept;
    logic [LANES-1:0] pipe_busy_d;

    assign accept  = in_valid_i & ready_q;
    assign cnt_inc = (cnt_q == CW'(MAX_BEATS)) ? cnt_q : cnt_q + CW'(1);

    // Tile framing: next state, beat count, drain countdown and done pulse.
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        tile_beats_d = tile_beats_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = CW'(1);
                    if (in_last_i) begin
                        if (LANES == 1) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                            dcnt_d  = DCW'(LANES - 1);
                        end
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (in_last_i) begin
                        if (LANES == 1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                            dcnt_d  = DCW'(LANES - 1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q - DCW'(1);
                if (dcnt_q == DCW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done_d) begin
            tile_beats_d = cnt_d;
        end
    end

    // Registered handshake and status outputs, derived from next-state values.
    always_comb begin
        ready_d = (state_d != ST_DRAIN);
        busy_d  = (state_d != ST_IDLE) | (|pipe_busy_d);
    end

    // Control state and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            dcnt_q       <= '0;
            cnt_q        <= '0;
            tile_beats_q <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            cnt_q        <= cnt_d;
            tile_beats_q <= tile_beats_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready_o   = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign tile_beats_o = tile_beats_q;

    // Per-lane skew chains: lane l is l+1 stages deep and never stalls.
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        logic [W-1:0] dat_q [0:l];
        logic [W-1:0] dat_d [0:l];
        logic [l:0]   vld_q;
        logic [l:0]   vld_d;

        // Stage 0 takes the lane element on accept, otherwise a zero bubble.
        always_comb begin
            dat_d[0] = accept ? in_data_i[l*W +: W] : '0;
            vld_d[0] = accept;
            for (int s = 1; s <= l; s++) begin
                dat_d[s] = dat_q[s-1];
                vld_d[s] = vld_q[s-1];
            end
        end

        // Chain registers; reset clears data and valid in every stage.
        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                dat_q <= '{default: '0};
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign pipe_busy_d[l]         = |vld_d;
        assign lane_data_o[l*W +: W]  = dat_q[l];
        assign lane_valid_o[l]        = vld_q[l];
    end

endmodule

// File: doc/sta_skew_feeder.md
# sta_skew_feeder

Edge feeder for the systolic tensor array. It accepts one operand vector per handshake, with one W-bit element per array lane. It emits the vector diagonally skewed, so lane l lags lane 0 by l cycles, which is the wavefront order the array edge consumes. One instance drives the data edge and a second drives the weight edge. It also frames tiles: it drains the skew pipeline after the last beat, pulses completion, and reports the tile length.

## Interface
- LANES, default 4: number of array lanes, ≥1.
- W, default 8: element width in bits (matches quantized_size).
- MAX_BEATS, default 255: saturation value of the beat counter.
- CW, derived as $clog2(MAX_BEATS+1): beat counter width.
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  feeder can accept a beat.
- in_last_i  in  1  accepted beat is the last of the tile.
- in_data_i  in  LANES*W  lane l element at [l*W +: W].
- lane_data_o  out  LANES*W  skewed elements to the array edge; lane l at [l*W +: W].
- lane_valid_o  out  LANES  per-lane valid for lane_data_o.
- busy_o  out  1  tile in progress or skew pipeline non-empty.
- done_o  out  1  one-cycle pulse when the final beat of a tile exits the last lane.
- tile_beats_o  out  CW  beats in the completed tile; valid while done_o=1, held until the next done_o.

## Operation
- Handshake: a beat is accepted on an edge where in_valid_i & in_ready_o = 1. in_data_i and in_last_i are sampled only on accepted edges.
- Skew pipeline: lane l is a register chain of depth l+1, carrying data and valid.
  - On an accepted edge, every lane stage-0 loads its element with valid=1.
  - On any other edge, stage-0 loads zero data with valid=0 (a bubble).
  - The pipeline advances every cycle. It never stalls. Bubbles propagate diagonally, so skew alignment is preserved.
- Invalid output slots always carry zero data, so array accumulators are unaffected.
- FSM states:
  - IDLE: in_ready_o=1. An accepted beat with in_last_i=0 moves to FEED. An accepted beat with in_last_i=1 moves to DRAIN, or straight to DONE behaviour if LANES=1.
  - FEED: in_ready_o=1. An accepted beat with in_last_i=1 moves to DRAIN. Missing beats insert bubbles.
  - DRAIN: in_ready_o=0. A counter loads LANES-1 on entry and decrements each edge. At 1 it returns to IDLE, and done_o asserts in the following cycle.
- Beat counter:
  - Counts accepted beats in the current tile, saturating at MAX_BEATS.
  - Cleared on entry to the next tile's first beat.
  - Copied to tile_beats_o when done_o asserts.
- busy_o = (state≠IDLE) | (|lane_valid pipeline contents).
- Reset (reset_i=0 on an edge), including mid-tile:
  - FSM goes to IDLE.
  - All pipeline stages clear to data 0 and valid 0.
  - The counter clears.
  - Any pending done is cancelled.

## Timing
- Beat accepted on edge E appears on lane l during the cycle after edge E+l. Lane 0 latency is 1 cycle; lane LANES-1 latency is LANES cycles.
- When the last beat is accepted on edge E:
  - in_ready_o=0 during the cycles after edges E … E+LANES-2 (LANES-1 cycles).
  - in_ready_o=1 again in the cycle after edge E+LANES-1. That is the same cycle done_o=1 and the last lane shows the final beat.
  - A new beat may be accepted in the done cycle with no output overlap.
- Back-to-back tiles lose exactly LANES-1 input cycles.
- Output values after reset: in_ready_o=1, lane_data_o=0, lane_valid_o=0, busy_o=0, done_o=0, tile_beats_o=0.
- A single-beat tile (in_last_i on the first beat) is legal.
- in_valid_i during DRAIN is ignored, and its data is not consumed.

## Test plan
- **Single tile:** LANES=4, W=8; 3 back-to-back beats {0x01,0x02,0x03,0x04}, {0x11…}, {0x21…}, last on the third beat (edge E).
  - Lane 3 shows 0x04, 0x14, 0x24 after edges E+1, E+2, E+3.
  - done_o=1 after edge E+3; tile_beats_o=3.
  - in_ready_o=0 for exactly 3 cycles.
- **Input gap:** beats at edges 0 and 2, last on edge 2.
  - Lane 2 shows valid, bubble (data 0, valid 0), valid after edges 2, 3, 4.
  - done_o after edge 5; tile_beats_o=2.
- **Back-to-back tiles:** second tile's first beat offered continuously.
  - Accepted in the done cycle of tile 1.
  - No lane carries data from both tiles in the same slot.
- **Single-beat tile, and LANES=1 build:**
  - LANES=4: done_o 3 cycles after acceptance.
  - LANES=1: in_ready_o never drops; done_o the cycle after acceptance.
- **Saturation:** MAX_BEATS=3; 5-beat tile → tile_beats_o=3.
- **Mid-tile reset:** reset_i=0 for one edge during FEED with the pipeline full.
  - Next cycle: all lane_valid_o=0, lane_data_o=0, busy_o=0, in_ready_o=1, and no done_o pulse ever follows.
